// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, flag bit positions.
// ALU_MC_DIV_EN selects whether UDIV is an iterative opcode.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_UDIV);
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the operand-read stage, the ALU and writeback.
interface alu_mc_if #(parameter int WIDTH = 64);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic [3:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] busW;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, busA, busB, ctrl, out_ready,
        input  in_ready, out_valid, busW, flags, err
    );

    modport slave (
        input  in_valid, busA, busB, ctrl, out_ready,
        output in_ready, out_valid, busW, flags, err
    );

endinterface

// File: rtl/alu_mc_iter.sv
// Iterative engine: shift-add MUL (B LSB first) and, with ALU_MC_DIV_EN, restoring UDIV
// (quotient MSB first). One bit per step; done pulses on the WIDTH-th step.
module alu_mc_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             start,
    input  logic             step,
`ifdef ALU_MC_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // MUL: acc = partial product, opa = shifted multiplicand, opb = remaining multiplier bits.
    // UDIV: acc = remainder, opa = dividend shifting into quotient, opb = divisor.
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx;
    logic [CNT_W-1:0] count;
`ifdef ALU_MC_DIV_EN
    logic             div_mode;
    logic [WIDTH:0]   rem_sh;
`endif

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_nx = opb[0] ? acc + opa : acc;
        opa_nx = opa << 1;
        opb_nx = opb >> 1;
        result = acc_nx;
`ifdef ALU_MC_DIV_EN
        rem_sh = {acc, opa[WIDTH-1]};
        if (div_mode) begin
            opb_nx = opb;
            if (rem_sh >= {1'b0, opb}) begin
                acc_nx = WIDTH'(rem_sh - {1'b0, opb});
                opa_nx = {opa[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh[WIDTH-1:0];
                opa_nx = {opa[WIDTH-2:0], 1'b0};
            end
            result = opa_nx;
        end
`endif
    end

    // NOTE: datapath registers carry no reset; start always reloads them before use.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= '0;
            opa   <= a;
            opb   <= b;
            count <= '0;
`ifdef ALU_MC_DIV_EN
            div_mode <= is_div;
`endif
        end else if (step) begin
            acc   <= acc_nx;
            opa   <= opa_nx;
            opb   <= opb_nx;
            count <= count + CNT_W'(1);
        end
    end

    assign done = step && (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops, iterative engine hookup, result/flag registers.
// Define ALU_MC_DIV_EN to enable the UDIV opcode.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic     Clk,
    input logic     Reset,
    alu_mc_if.slave bus
);

    state_t           state, state_nx;
    logic             accept, iter_start, iter_done;
    logic [WIDTH-1:0] iter_res, fin_res;
    logic             fin_err;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_err;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign accept     = bus.in_valid && bus.in_ready;
    assign iter_start = accept && is_iter_op(bus.ctrl);

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (Clk),
        .start  (iter_start),
        .step   (state == BUSY),
`ifdef ALU_MC_DIV_EN
        .is_div (bus.ctrl == OP_UDIV),
`endif
        .a      (bus.busA),
        .b      (bus.busB),
        .result (iter_res),
        .done   (iter_done)
    );

`ifdef ALU_MC_DIV_EN
    logic div_zero;
    always_ff @(posedge Clk) begin
        if (accept) div_zero <= (bus.ctrl == OP_UDIV) && (bus.busB == '0);
    end
    assign fin_res = div_zero ? '0 : iter_res;
    assign fin_err = div_zero;
`else
    assign fin_res = iter_res;
    assign fin_err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = is_iter_op(bus.ctrl) ? BUSY : DONE;
            BUSY:    if (iter_done) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Single-cycle ops work straight off the bus at accept; MUL/UDIV land in the default arm unused.
    always_comb begin
        sum    = {1'b0, bus.busA} + {1'b0, bus.busB};
        diff   = {1'b0, bus.busA} - {1'b0, bus.busB};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (bus.ctrl)
            OP_AND:   sc_res = bus.busA & bus.busB;
            OP_ORR:   sc_res = bus.busA | bus.busB;
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (bus.busA[WIDTH-1] == bus.busB[WIDTH-1]) && (sum[WIDTH-1] != bus.busA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = ~diff[WIDTH];
                sc_v   = (bus.busA[WIDTH-1] != bus.busB[WIDTH-1]) && (diff[WIDTH-1] != bus.busA[WIDTH-1]);
            end
            OP_PASSB: sc_res = bus.busB;
            default:  sc_err = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.busW  <= '0;
            bus.flags <= '0;
            bus.err   <= 1'b0;
        end else if (accept && !is_iter_op(bus.ctrl)) begin
            bus.busW  <= sc_res;
            bus.flags <= pack_flags(sc_res, sc_c, sc_v);
            bus.err   <= sc_err;
        end else if (iter_done) begin
            bus.busW  <= fin_res;
            bus.flags <= pack_flags(fin_res, 1'b0, 1'b0);
            bus.err   <= fin_err;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: arithmetic reference model with per-cycle scoreboard compare,
// plus directed vectors with literal expectations.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;
        logic         err;
        int           lat;
        int           acc_cyc;
        bit           seen;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.Clk(clk), .Reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t                  e;
        logic signed [W+1:0]   sa, sb, sr, smax, smin;
        logic [2*W-1:0]        p;
        logic                  c, v;
        e.res = '0; e.err = 1'b0; e.lat = 1; e.acc_cyc = 0; e.seen = 1'b0;
        c = 1'b0; v = 1'b0;
        sa   = $signed({{2{a[W-1]}}, a});
        sb   = $signed({{2{b[W-1]}}, b});
        smax = $signed({3'b000, {(W-1){1'b1}}});
        smin = -smax - 1;
        case (op)
            OP_AND:   e.res = a & b;
            OP_ORR:   e.res = a | b;
            OP_PASSB: e.res = b;
            OP_ADD: begin
                e.res = a + b;
                c  = (e.res < a);
                sr = sa + sb;
                v  = (sr > smax) || (sr < smin);
            end
            OP_SUB: begin
                e.res = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > smax) || (sr < smin);
            end
            OP_MUL: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.lat = W + 1;
            end
`ifdef ALU_MC_DIV_EN
            OP_UDIV: begin
                e.lat = W + 1;
                if (b == '0) e.err = 1'b1;
                else         e.res = a / b;
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.flags = {e.res[W-1], (e.res == '0), c, v};
        return e;
    endfunction

    // Track accepts and output handshakes at the clock edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e = model(bus.ctrl, bus.busA, bus.busB);
                e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
        end
        cyc++;
    end

    // Scoreboard compare on the falling edge, every cycle out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", bus.in_ready, exp_q.size() == 0);
            if (exp_q.size() > 0 && (cyc - exp_q[0].acc_cyc) >= exp_q[0].lat)
                check("out_valid_due", bus.out_valid, 1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_out_valid", bus.out_valid, 0);
                end else begin
                    check("sb_busW", bus.busW, exp_q[0].res);
                    check("sb_flags", bus.flags, exp_q[0].flags);
                    check("sb_err", bus.err, exp_q[0].err);
                    if (!exp_q[0].seen) begin
                        check("sb_latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                        exp_q[0].seen = 1'b1;
                    end
                end
            end
        end
    end

    // Entered and left at #1 after a rising edge.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.busA     = a;
        bus.busB     = b;
        bus.ctrl     = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.busA     = {$urandom(), $urandom()};
        bus.busB     = {$urandom(), $urandom()};
        bus.ctrl     = 4'($urandom());
    endtask

    task automatic run_lit(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef,
                           input logic eerr);
        exp_t m;
        int   n = 0;
        m = model(op, a, b);
        check({tag, "_model_res"}, m.res, er);
        check({tag, "_model_flags"}, m.flags, ef);
        do_op(op, a, b);
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_busW"}, bus.busW, er);
        check({tag, "_flags"}, bus.flags, ef);
        check({tag, "_err"}, bus.err, eerr);
        if (bus.out_ready) begin
            n = 0;
            @(posedge clk); #1;
            while (!bus.in_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check({tag, "_idle"}, bus.in_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.busA      = '0;
        bus.busB      = '0;
        bus.ctrl      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busW", bus.busW, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_err", bus.err, 0);
        @(posedge clk); #1;

        run_lit("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
        run_lit("add_carry", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1'b0);
        run_lit("sub_eq", OP_SUB, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0);
        run_lit("sub_neg", OP_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
        run_lit("sub_ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);
        run_lit("and", OP_AND, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
                64'h0F00_0F00_0F00_0F00, 4'b0000, 1'b0);
        run_lit("passb", OP_PASSB, 64'h1234, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b1000, 1'b0);
        run_lit("illegal", 4'b0011, 64'd9, 64'd4, 64'd0, 4'b0100, 1'b1);
        run_lit("mul", OP_MUL, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 4'b0000, 1'b0);
        run_lit("mul_ones", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 1'b0);
`ifdef ALU_MC_DIV_EN
        run_lit("udiv", OP_UDIV, 64'd100, 64'd7, 64'd14, 4'b0000, 1'b0);
        run_lit("udiv_zero", OP_UDIV, 64'd123, 64'd0, 64'd0, 4'b0100, 1'b1);
`else
        run_lit("op1001", OP_UDIV, 64'd100, 64'd7, 64'd0, 4'b0100, 1'b1);
`endif

        // Backpressure: result held while the consumer stalls.
        bus.out_ready = 1'b0;
        run_lit("bp_orr", OP_ORR, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("bp_busW", bus.busW, 64'hFF);
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_drop", bus.out_valid, 0);
        check("bp_ready_back", bus.in_ready, 1);
        @(posedge clk); #1;

        // Reset in the middle of a MUL discards it.
        run_lit("pre_rst", OP_ORR, 64'h5A, 64'h0, 64'h5A, 4'b0000, 1'b0);
        do_op(OP_MUL, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0001);
        repeat (19) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busW", bus.busW, 0);
        check("abort_flags", bus.flags, 0);
        check("abort_err", bus.err, 0);
        repeat (80) @(posedge clk);
        #1;
        run_lit("post_rst", OP_ADD, 64'd40, 64'd2, 64'd42, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
